// File: rtl/encoder_4to2.sv
// Clocked 4-to-2 priority encoder (highest set bit wins) with valid and multi-hot error flags.
// Optional macro ENC_STICKY_ERR_EN adds err_sticky, a flag that latches any multi-hot input until reset.
module encoder_4to2 #(
    parameter bit OUT_REG = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] d,
    output logic [1:0] y,
    output logic       valid,
    output logic       err
`ifdef ENC_STICKY_ERR_EN
    ,
    output logic       err_sticky
`endif
);

    function automatic logic [1:0] enc_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'b00;
        if (v[3])      idx = 2'b11;
        else if (v[2]) idx = 2'b10;
        else if (v[1]) idx = 2'b01;
        return idx;
    endfunction

    // Clearing the lowest set bit leaves something behind only when two or more bits are set.
    function automatic logic enc_multi(input logic [3:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

    logic [1:0] y_p0;
    logic       valid_p0;
    logic       err_p0;

    // ---- stage p0: combinational encode of d ----
    assign y_p0     = enc_index(d);
    assign valid_p0 = |d;
    assign err_p0   = enc_multi(d);

    generate
        if (OUT_REG) begin : g_reg
            logic [1:0] y_p1;
            logic       valid_p1;
            logic       err_p1;

            // ---- stage p1: registered outputs ----
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    y_p1     <= 2'b00;
                    valid_p1 <= 1'b0;
                    err_p1   <= 1'b0;
                end else if (en) begin
                    y_p1     <= y_p0;
                    valid_p1 <= valid_p0;
                    err_p1   <= err_p0;
                end
            end

            assign y     = y_p1;
            assign valid = valid_p1;
            assign err   = err_p1;
        end else begin : g_comb
            assign y     = y_p0;
            assign valid = valid_p0;
            assign err   = err_p0;
        end
    endgenerate

`ifdef ENC_STICKY_ERR_EN
    // Watches the raw encode of d, so it sees multi-hot inputs even while en=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_sticky <= 1'b0;
        else if (err_p0)
            err_sticky <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_encoder_4to2.sv
// Scoreboard bench for encoder_4to2 (OUT_REG=1): driver queues expected results, monitor checks them.
module tb_encoder_4to2;

    typedef struct packed {
        logic [1:0] y;
        logic       valid;
        logic       err;
        logic       sticky;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [3:0] d = 4'b1000;
    logic [1:0] y;
    logic       valid;
    logic       err;
`ifdef ENC_STICKY_ERR_EN
    logic       err_sticky;
`endif

    int passed = 0;
    int total  = 0;

    exp_t exp_q[$];
    exp_t held;     // what the outputs should currently show
    logic sticky_m;

    encoder_4to2 #(.OUT_REG(1'b1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .d(d),
        .y(y),
        .valid(valid),
        .err(err)
`ifdef ENC_STICKY_ERR_EN
        ,
        .err_sticky(err_sticky)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: index of the highest set bit, any-set, and at-least-two-set.
    function automatic exp_t model(input logic [3:0] v, input logic stk);
        exp_t e;
        e.y = 2'b00;
        for (int i = 0; i < 4; i++)
            if (v[i]) e.y = 2'(i);
        e.valid  = (v != 4'd0);
        e.err    = ($countones(v) >= 2);
        e.sticky = stk;
        return e;
    endfunction

    task automatic step(input logic [3:0] dv, input logic ev);
        @(negedge clk);
        d  = dv;
        en = ev;
        if ($countones(dv) >= 2) sticky_m = 1'b1;
        if (ev) held = model(dv, sticky_m);
        else    held.sticky = sticky_m;
        exp_q.push_back(held);
    endtask

    task automatic chk_zero(input string name);
        chk({name, ".y"}, int'(y), 0);
        chk({name, ".valid"}, int'(valid), 0);
        chk({name, ".err"}, int'(err), 0);
`ifdef ENC_STICKY_ERR_EN
        chk({name, ".sticky"}, int'(err_sticky), 0);
`endif
    endtask

    task automatic drain();
        int budget;
        budget = 10;
        @(posedge clk);
        #2;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Monitor: the registered outputs are sampled 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("y", int'(y), int'(e.y));
                chk("valid", int'(valid), int'(e.valid));
                chk("err", int'(err), int'(e.err));
`ifdef ENC_STICKY_ERR_EN
                chk("err_sticky", int'(err_sticky), int'(e.sticky));
`endif
            end
        end
    end

    initial begin
        sticky_m = 1'b0;
        held     = '0;

        // Reset held with a live input while the clock runs.
        #1;
        chk_zero("rst_initial");
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_zero("rst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;

        // One-hot sweep, zero input, multi-hot cases.
        step(4'b0001, 1'b1);
        step(4'b0010, 1'b1);
        step(4'b0100, 1'b1);
        step(4'b1000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b1100, 1'b1);
        step(4'b0011, 1'b1);
        step(4'b1111, 1'b1);

        // Enable hold.
        step(4'b0010, 1'b1);
        repeat (3) step(4'b1000, 1'b0);
        step(4'b1000, 1'b1);

        // Randomised traffic with occasional enable drops.
        for (int i = 0; i < 200; i++)
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        drain();

        // Asynchronous reset between edges clears outputs without a clock edge.
        step(4'b1010, 1'b1);
        drain();
        rst_n = 1'b0;
        #1;
        chk_zero("rst_async");
        d  = 4'b1000;
        en = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_zero("rst_mid_hold");
        end
        @(negedge clk);
        rst_n    = 1'b1;
        sticky_m = 1'b0;
        held     = '0;

        // Multi-hot then clean input: err drops, sticky flag (if built) persists.
        step(4'b0110, 1'b1);
        step(4'b0001, 1'b1);
        step(4'b0001, 1'b0);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/encoder_4to2.md
Name: encoder_4to2

Overview:
- Clocked 4-to-2 binary encoder with highest-bit-wins priority resolution.
- Reports whether the input was valid (any bit set) and flags multi-hot inputs as errors.
- Small utility block placed between request/select lines and logic that needs a 2-bit index.
- Outputs are registered by default, for timing isolation.

Parameters:
- OUT_REG, default 1: 1 = outputs registered, one cycle latency; 0 = outputs combinational from d, and clk/rst_n have no effect on y/valid/err.

Ports:
- clk  input  1  system clock; rising edge active.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  sample enable. When 0, registered outputs hold their value. Ignored when OUT_REG=0.
- d  input  4  input lines; bit i asserted means index i is requested.
- y  output  2  encoded index of the highest set bit of d.
- valid  output  1  1 when at least one bit of d is set.
- err  output  1  1 when more than one bit of d is set (multi-hot).
- err_sticky  output  1  present only with ENC_STICKY_ERR_EN; see Optional Feature.

Behaviour:
- Encode function, combinational, of d:
  - d[3]=1 -> y=2'b11.
  - else d[2]=1 -> 2'b10.
  - else d[1]=1 -> 2'b01.
  - else d[0]=1 -> 2'b00.
  - d=4'b0000 -> y=2'b00.
- valid = |d.
- err = 1 when popcount(d) >= 2. Examples: 4'b1100, 4'b0011, 4'b1111 all give err=1.
- One-hot inputs: y = index of the set bit, valid=1, err=0.
- Zero input: y=00, valid=0, err=0. Consumers must qualify y with valid to tell "index 0" apart from "none".
- OUT_REG=1:
  - y, valid and err update on the rising clk edge when en=1, with the encode of the d present before the edge.
  - Latency is exactly one cycle.
  - When en=0, all outputs hold.
- Reset (rst_n=0):
  - Asynchronous assertion forces y=00, valid=0, err=0 (and err_sticky=0) immediately, independent of clk.
  - Deassertion is synchronous to the design clock externally. The first sample is taken at the first rising edge with rst_n=1 and en=1.
  - Reset asserted mid-operation overrides en and d.
- OUT_REG=0:
  - Outputs follow d combinationally with zero latency.
  - Reset and en do not affect y/valid/err.
- An X/Z on d is not a defined input; no requirement applies.

Optional Feature:
- Macro: ENC_STICKY_ERR_EN.
- Defined:
  - Adds output err_sticky, a register cleared only by rst_n.
  - Set on the first rising clk edge at which the computed err is 1, regardless of en and OUT_REG.
  - Stays 1 until reset.
- Not defined:
  - Port err_sticky does not exist and no extra flops are inferred.
  - All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with d=4'b1000 and toggle clk -> y=00, valid=0, err=0 throughout. Assert rst_n asynchronously between edges -> outputs clear without waiting for an edge.
- One-hot sweep, en=1, OUT_REG=1: apply d=0001, 0010, 0100, 1000 on successive cycles -> one cycle later y=00, 01, 10, 11 respectively, valid=1, err=0.
- Zero input: d=4'b0000 -> next cycle y=00, valid=0, err=0.
- Multi-hot: d=4'b1100 -> y=11, valid=1, err=1. d=4'b0011 -> y=01, err=1. d=4'b1111 -> y=11, err=1.
- Enable hold: register d=0010 (y=01), then set en=0 and apply d=1000 for 3 cycles -> y stays 01, valid=1. Restore en=1 -> y=11 one cycle later.
- With ENC_STICKY_ERR_EN: apply d=0110 for one cycle, then d=0001 -> err drops to 0 but err_sticky stays 1. Pulse rst_n low -> err_sticky=0. With OUT_REG=0 build: d changes -> y/valid/err change in the same delta with no clock.
